// File: rtl/path_delay_pkg.sv
// path_delay_pkg -- shared types for the path-delay filter.
//   chan_state_t : per-channel scheduler state (IDLE, PEND1, PEND2, GHOST)
//   slot_t       : one scheduled event {value, remaining, elapsed}
//   DEF_N_CH / DEF_CNT_W : default channel count and counter width
// Slot counters are MAX_CNT_W wide so one struct type serves any
// CNT_W <= MAX_CNT_W; saturation is applied at the CNT_W limit.
package path_delay_pkg;

    localparam int unsigned DEF_N_CH  = 4;
    localparam int unsigned DEF_CNT_W = 8;
    localparam int unsigned MAX_CNT_W = 32;

    typedef logic [MAX_CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND1 = 2'd1,
        PEND2 = 2'd2,
        GHOST = 2'd3
    } chan_state_t;

    typedef struct packed {
        logic value;
        cnt_t rem;
        cnt_t elapsed;
    } slot_t;

    // One cycle of ageing: remaining counts down (never below 1, so a
    // transport event queued behind a slower one matures right after it),
    // elapsed counts up and saturates at sat.
    function automatic slot_t count_slot(slot_t s, cnt_t sat);
        slot_t r;
        r = s;
        if (s.rem > cnt_t'(1))
            r.rem = s.rem - cnt_t'(1);
        if (s.elapsed < sat)
            r.elapsed = s.elapsed + cnt_t'(1);
        return r;
    endfunction

endpackage

// File: rtl/path_delay_chan.sv
// path_delay_chan -- one channel of the path-delay filter.
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_i              : raw channel input
//   rise_dly_i/fall_dly_i : delay for 0->1 / 1->0 events (0 treated as 1)
//   reject_lim_i      : narrower pulses vanish silently
//   error_lim_i       : narrower pulses (>= reject) are cancelled/reported
//   on_detect_i       : report cancellation at detection (1) or at the
//                       cancelled event's scheduled time (0)
//   show_cancel_i     : enable cancel_o reporting
//   out_o             : delayed, filtered output (registered)
//   cancel_o, ovf_o   : one-cycle pulses for cancellation / queue overflow
module path_delay_chan
    import path_delay_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_i,
    input  logic [CNT_W-1:0] rise_dly_i,
    input  logic [CNT_W-1:0] fall_dly_i,
    input  logic [CNT_W-1:0] reject_lim_i,
    input  logic [CNT_W-1:0] error_lim_i,
    input  logic             on_detect_i,
    input  logic             show_cancel_i,
    output logic             out_o,
    output logic             cancel_o,
    output logic             ovf_o
);

    localparam cnt_t SAT = cnt_t'((64'd1 << CNT_W) - 64'd1);

    chan_state_t state, state_n;
    slot_t       slot_a, slot_b, a_n, b_n, new_ev;
    logic        in_q, edge_det;
    logic        out_n, cancel_n, cancel_dly, cancel_dly_n, ovf_n, ovf_dly, ovf_dly_n;
    cnt_t        dly_raw, rej, err;

    assign edge_det = in_i ^ in_q;
    assign dly_raw  = in_i ? cnt_t'(rise_dly_i) : cnt_t'(fall_dly_i);
    assign rej      = cnt_t'(reject_lim_i);
    assign err      = cnt_t'(error_lim_i);

    always_comb begin
        new_ev.value   = in_i;
        new_ev.rem     = (dly_raw == '0) ? cnt_t'(1) : dly_raw;
        new_ev.elapsed = '0;
    end

    // Two phases per cycle: age the slots and retire a matured slot A,
    // then handle an input edge starting from the state that leaves.
    // After phase one a_n.elapsed already equals A.elapsed+1, i.e. the
    // width of the pulse that this edge terminates.
    always_comb begin
        state_n      = state;
        a_n          = slot_a;
        b_n          = slot_b;
        out_n        = out_o;
        cancel_n     = cancel_dly;
        cancel_dly_n = 1'b0;
        ovf_n        = ovf_dly;
        ovf_dly_n    = 1'b0;

        case (state)
            PEND1: begin
                if (slot_a.rem == cnt_t'(1)) begin
                    out_n   = slot_a.value;
                    a_n     = '0;
                    state_n = IDLE;
                end else begin
                    a_n = count_slot(slot_a, SAT);
                end
            end
            PEND2: begin
                if (slot_a.rem == cnt_t'(1)) begin
                    out_n   = slot_a.value;
                    a_n     = count_slot(slot_b, SAT);
                    b_n     = '0;
                    state_n = PEND1;
                end else begin
                    a_n = count_slot(slot_a, SAT);
                    b_n = count_slot(slot_b, SAT);
                end
            end
            GHOST: begin
                if (slot_a.rem == cnt_t'(1)) begin
                    cancel_n = 1'b1;
                    a_n      = '0;
                    state_n  = IDLE;
                end else begin
                    a_n = count_slot(slot_a, SAT);
                end
            end
            default: ;
        endcase

        if (edge_det) begin
            case (state_n)
                IDLE: begin
                    a_n     = new_ev;
                    state_n = PEND1;
                end
                GHOST: begin
                    cancel_n = 1'b1;
                    a_n      = new_ev;
                    state_n  = PEND1;
                end
                PEND1: begin
                    if (a_n.elapsed < rej) begin
                        a_n     = '0;
                        state_n = IDLE;
                    end else if (a_n.elapsed < err) begin
                        if (show_cancel_i && !on_detect_i) begin
                            state_n = GHOST;
                        end else begin
                            cancel_dly_n = show_cancel_i;
                            a_n          = '0;
                            state_n      = IDLE;
                        end
                    end else begin
                        b_n     = new_ev;
                        state_n = PEND2;
                    end
                end
                PEND2: begin
                    b_n       = '0;
                    ovf_dly_n = 1'b1;
                    state_n   = PEND1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            slot_a     <= '0;
            slot_b     <= '0;
            in_q       <= 1'b0;
            out_o      <= 1'b0;
            cancel_o   <= 1'b0;
            ovf_o      <= 1'b0;
            cancel_dly <= 1'b0;
            ovf_dly    <= 1'b0;
        end else begin
            state      <= state_n;
            slot_a     <= a_n;
            slot_b     <= b_n;
            in_q       <= in_i;
            out_o      <= out_n;
            cancel_o   <= cancel_n;
            ovf_o      <= ovf_n;
            cancel_dly <= cancel_dly_n;
            ovf_dly    <= ovf_dly_n;
        end
    end

endmodule

// File: rtl/path_delay_filter.sv
// path_delay_filter -- N_CH independent delay/pulse-filter channels that
// share one configuration.
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_i         : raw channel inputs [N_CH]
//   rise_dly_i, fall_dly_i, reject_lim_i, error_lim_i [CNT_W]
//   on_detect_i, show_cancel_i : cancellation reporting controls
//   out_o, cancel_o, ovf_o [N_CH] : per-channel outputs
module path_delay_filter
    import path_delay_pkg::*;
#(
    parameter int unsigned N_CH  = DEF_N_CH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  in_i,
    input  logic [CNT_W-1:0] rise_dly_i,
    input  logic [CNT_W-1:0] fall_dly_i,
    input  logic [CNT_W-1:0] reject_lim_i,
    input  logic [CNT_W-1:0] error_lim_i,
    input  logic             on_detect_i,
    input  logic             show_cancel_i,
    output logic [N_CH-1:0]  out_o,
    output logic [N_CH-1:0]  cancel_o,
    output logic [N_CH-1:0]  ovf_o
);

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        path_delay_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk           (clk),
            .rst_n         (rst_n),
            .in_i          (in_i[g]),
            .rise_dly_i    (rise_dly_i),
            .fall_dly_i    (fall_dly_i),
            .reject_lim_i  (reject_lim_i),
            .error_lim_i   (error_lim_i),
            .on_detect_i   (on_detect_i),
            .show_cancel_i (show_cancel_i),
            .out_o         (out_o[g]),
            .cancel_o      (cancel_o[g]),
            .ovf_o         (ovf_o[g])
        );
    end

endmodule

// File: tb/tb_path_delay_filter.sv
// tb_path_delay_filter -- directed scenarios for path_delay_filter.
// Cycle c is the c-th rising edge after reset release; in_i for cycle c is
// set before that edge and outputs for cycle c are sampled 1 time unit
// after it. Expected per-cycle outputs are queued when a cycle's stimulus
// is driven and popped for comparison once the edge has happened.
module tb_path_delay_filter;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned CNT_W = 8;
    localparam int          LEN   = 30;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N_CH-1:0]  in_i;
    logic [CNT_W-1:0] rise_dly, fall_dly, rej_lim, err_lim;
    logic             on_det, show_can;
    logic [N_CH-1:0]  out_o, cancel_o, ovf_o;

    typedef struct {
        int              cyc;
        logic [N_CH-1:0] out;
        logic [N_CH-1:0] can;
        logic [N_CH-1:0] ovf;
    } exp_t;

    typedef int ev_t [4];

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    path_delay_filter #(
        .N_CH  (N_CH),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_i          (in_i),
        .rise_dly_i    (rise_dly),
        .fall_dly_i    (fall_dly),
        .reject_lim_i  (rej_lim),
        .error_lim_i   (err_lim),
        .on_detect_i   (on_det),
        .show_cancel_i (show_can),
        .out_o         (out_o),
        .cancel_o      (cancel_o),
        .ovf_o         (ovf_o)
    );

    always #5 clk = ~clk;

    // Level after applying every toggle listed in ev up to and including c.
    function automatic logic level(ev_t ev, int c, logic init);
        logic l;
        l = init;
        for (int i = 0; i < 4; i++)
            if (ev[i] >= 0 && ev[i] <= c)
                l = ~l;
        return l;
    endfunction

    function automatic logic hit(ev_t ev, int c);
        logic h;
        h = 1'b0;
        for (int i = 0; i < 4; i++)
            if (ev[i] == c)
                h = 1'b1;
        return h;
    endfunction

    task automatic check(input string tag, input logic [N_CH-1:0] act, input logic [N_CH-1:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: got %b, expected %b", tag, act, exp);
        end
    endtask

    task automatic run(input string tag, input int ch,
                       input int rise, input int fall, input int rj, input int er,
                       input logic o_d, input logic s_c, input logic init, input int rst_at,
                       input ev_t in_ev, input ev_t out_ev, input ev_t can_ev, input ev_t ovf_ev);
        exp_t e, g;
        rise_dly = CNT_W'(rise);
        fall_dly = CNT_W'(fall);
        rej_lim  = CNT_W'(rj);
        err_lim  = CNT_W'(er);
        on_det   = o_d;
        show_can = s_c;

        @(negedge clk);
        rst_n = 1'b0;
        in_i  = '0;
        in_i[ch] = init;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s reset out", tag), out_o, '0);
            check($sformatf("%s reset cancel", tag), cancel_o, '0);
            check($sformatf("%s reset ovf", tag), ovf_o, '0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int c = 1; c <= LEN; c++) begin
            if (c == rst_at)
                rst_n = 1'b0;
            if (rst_at > 0 && c == rst_at + 2)
                rst_n = 1'b1;
            in_i = '0;
            in_i[ch] = level(in_ev, c, init);
            e.cyc = c;
            e.out = '0;
            e.can = '0;
            e.ovf = '0;
            e.out[ch] = level(out_ev, c, 1'b0);
            e.can[ch] = hit(can_ev, c);
            e.ovf[ch] = hit(ovf_ev, c);
            sb.push_back(e);

            @(posedge clk);
            #1;
            g = sb.pop_front();
            check($sformatf("%s c%0d out", tag, g.cyc), out_o, g.out);
            check($sformatf("%s c%0d cancel", tag, g.cyc), cancel_o, g.can);
            check($sformatf("%s c%0d ovf", tag, g.cyc), ovf_o, g.ovf);
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_i     = '0;
        rise_dly = '0;
        fall_dly = '0;
        rej_lim  = '0;
        err_lim  = '0;
        on_det   = 1'b0;
        show_can = 1'b0;

        // name  ch rise fall rej err od sc init rst  in_ev  out_ev  can_ev  ovf_ev
        run("basic",     0, 4, 2, 2, 3, 1'b1, 1'b1, 1'b0, -1,
            '{10, 20, -1, -1}, '{14, 22, -1, -1}, '{-1, -1, -1, -1}, '{-1, -1, -1, -1});
        run("reject1",   1, 4, 2, 2, 3, 1'b1, 1'b1, 1'b0, -1,
            '{10, 11, -1, -1}, '{-1, -1, -1, -1}, '{-1, -1, -1, -1}, '{-1, -1, -1, -1});
        run("cancel_det", 2, 4, 2, 2, 3, 1'b1, 1'b1, 1'b0, -1,
            '{10, 12, -1, -1}, '{-1, -1, -1, -1}, '{13, -1, -1, -1}, '{-1, -1, -1, -1});
        run("cancel_sch", 3, 4, 2, 2, 3, 1'b0, 1'b1, 1'b0, -1,
            '{10, 12, -1, -1}, '{-1, -1, -1, -1}, '{14, -1, -1, -1}, '{-1, -1, -1, -1});
        run("transport", 0, 6, 6, 2, 3, 1'b1, 1'b1, 1'b0, -1,
            '{10, 14, -1, -1}, '{16, 20, -1, -1}, '{-1, -1, -1, -1}, '{-1, -1, -1, -1});
        run("overflow",  1, 6, 6, 2, 3, 1'b1, 1'b1, 1'b0, -1,
            '{10, 14, 15, -1}, '{16, -1, -1, -1}, '{-1, -1, -1, -1}, '{16, -1, -1, -1});
        run("no_show",   2, 4, 2, 2, 3, 1'b1, 1'b0, 1'b0, -1,
            '{10, 12, -1, -1}, '{-1, -1, -1, -1}, '{-1, -1, -1, -1}, '{-1, -1, -1, -1});
        run("held_high", 3, 4, 2, 2, 3, 1'b1, 1'b1, 1'b1, -1,
            '{-1, -1, -1, -1}, '{5, -1, -1, -1}, '{-1, -1, -1, -1}, '{-1, -1, -1, -1});
        run("mid_reset", 0, 4, 2, 2, 3, 1'b1, 1'b1, 1'b0, 12,
            '{10, 12, -1, -1}, '{-1, -1, -1, -1}, '{-1, -1, -1, -1}, '{-1, -1, -1, -1});
        run("ghost_edge", 1, 6, 2, 2, 3, 1'b0, 1'b1, 1'b0, -1,
            '{10, 12, 13, -1}, '{19, -1, -1, -1}, '{13, -1, -1, -1}, '{-1, -1, -1, -1});
        run("min_delay", 2, 0, 1, 0, 0, 1'b1, 1'b1, 1'b0, -1,
            '{10, 20, -1, -1}, '{11, 21, -1, -1}, '{-1, -1, -1, -1}, '{-1, -1, -1, -1});
        run("err_bound", 3, 4, 2, 2, 3, 1'b1, 1'b1, 1'b0, -1,
            '{10, 13, -1, -1}, '{14, 15, -1, -1}, '{-1, -1, -1, -1}, '{-1, -1, -1, -1});
        run("mat_edge",  0, 4, 2, 2, 3, 1'b1, 1'b1, 1'b0, -1,
            '{10, 14, -1, -1}, '{14, 16, -1, -1}, '{-1, -1, -1, -1}, '{-1, -1, -1, -1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
